spi_register_controller: RTL and testbench
==========================================

// Module: spi_register_controller
// PURPOSE
//  SPI target (mode 0, MSB first) frame controller sitting after spi_synchronizer.
//  - Decodes clk-domain sck/sdi/cs into command/address/data bytes.
//  - Drives a simple register-file port: 1-cycle write strobe, 1-cycle-latency read.
//  - Shifts read data back out on sdo.
//  - Every host transaction to the block's register space is sequenced here.
// PARAMETERS
//  ADDR_WIDTH      7  register address bits; 1..7, taken from command byte bits [ADDR_WIDTH-1:0]
//  AUTO_INCREMENT  1  1: address +1 after each data byte (wraps); 0: address fixed for frame
// PORTS
//  clk           in   1           system clock; all logic on posedge
//  reset         in   1           synchronous, active-high reset
//  sck           in   1           synchronized SPI clock (spi_synchronizer sck_out)
//  sdi           in   1           synchronized SPI data in (sdi_out)
//  cs            in   1           synchronized chip select, active low (cs_out)
//  sdo           out  1           SPI data out, MSB first
//  sdo_oe        out  1           1 while cs low; tristate enable for sdo pad
//  wr_en         out  1           one-cycle write strobe
//  wr_addr       out  ADDR_WIDTH  write address, valid with wr_en
//  wr_data       out  8           write data, valid with wr_en
//  rd_en         out  1           one-cycle read request
//  rd_addr       out  ADDR_WIDTH  read address, valid with rd_en
//  rd_data       in   8           read data, sampled exactly 1 cycle after rd_en
//  frame_active  out  1           1 from cs fall detect until cs rise detect
//  frame_error   out  1           one-cycle pulse: cs rose with partial byte (bit_cnt != 0)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; bit_cnt 0; shift regs 0; sck_q 1, cs_q 1.
//  - Edge detect: sck_q <= sck.
//    - rise = sck & ~sck_q; fall = ~sck & sck_q.
//    - Edges ignored while cs = 1.
//  - Timing requirement: sck high and low phases each >= 4 clk cycles (after sync).
//  - States: IDLE -> CMD -> {WRITE, READ}; any state -> IDLE on cs = 1 (same cycle).
//  - IDLE:
//    - cs = 0 -> CMD, bit_cnt = 0, frame_active = 1.
//    - tx_shift = 8'h00 so sdo = 0.
//  - Bit shift: on rise, rx_shift <= {rx_shift[6:0], sdi}; bit_cnt++ (3-bit, wraps 7->0).
//  - Byte complete: rise with bit_cnt == 7.
//  - CMD byte complete:
//    - addr <= cmd[ADDR_WIDTH-1:0].
//    - cmd[7] = 1 -> WRITE.
//    - cmd[7] = 0 -> READ, and rd_en pulses next cycle with rd_addr = addr.
//  - WRITE byte complete:
//    - Next cycle: wr_en = 1, wr_addr = addr, wr_data = byte.
//    - Then addr += AUTO_INCREMENT (mod 2^ADDR_WIDTH).
//  - READ data path:
//    - tx_shift <= rd_data on the cycle after rd_en.
//    - sdo = tx_shift[7] combinationally.
//    - On fall with bit_cnt != 0, tx_shift <= {tx_shift[6:0], 1'b0}.
//    - The fall following a byte boundary does not shift, so the freshly loaded MSB is presented.
//  - READ byte complete:
//    - addr += AUTO_INCREMENT.
//    - rd_en pulses next cycle with the new addr (prefetch for the next byte).
//    - Bits sampled on sdi during READ are ignored.
//  - Frame end (cs = 1 while not IDLE):
//    - -> IDLE, bit_cnt = 0, partial byte discarded.
//    - No wr_en for a partial byte.
//    - frame_error pulses if bit_cnt != 0.
//    - frame_active falls in the same cycle.
//  - Trailing prefetch: a read prefetch issued at frame end is harmless; its data is dropped.
//  - Simultaneous events: cs rise in the same cycle as a byte-complete rise → cs wins.
//    - The byte is dropped.
//    - No wr_en/rd_en is issued.
//  - Reset mid-frame: immediate return to reset values.
//    - Resumes only after cs is seen high, then low again.
//  - wr_en and rd_en are never asserted in the same cycle.
// TESTING
//  - Reset in every state → all outputs 0.
//  - Frame with cs held high the whole time → no strobes.
//  - Write: cs low, bytes 8'h85, 8'hA5, 8'h3C
//    → wr_en @addr 0x05 data 0xA5, then @0x06 data 0x3C; exactly 2 strobes.
//  - Read: cmd 8'h10, rd_data returns 0x5A for addr 0x10 and 0xC3 for 0x11
//    → sdo shifts 01011010 then 11000011.
//    → rd_en at 0x10, 0x11, 0x12.
//  - Wrap: write cmd 8'hFF + 2 data bytes → wr_addr 0x7F then 0x00.
//    - Repeat with AUTO_INCREMENT = 0 → 0x7F twice.
//  - Abort: cmd 8'h81, then cs rises after 5 data bits
//    → no wr_en, frame_error one pulse, state IDLE, frame_active 0.
//  - Collision: cs rise in the same clk as the 8th rise of a data byte
//    → no wr_en, frame_error 0.
//  - Reset mid-frame → outputs 0; next frame decodes normally.

Source files
------------

// File: rtl/spi_register_controller.sv
// SPI mode-0 target frame controller: decodes command/address/data bytes from
// synchronized SPI lines and sequences register-file writes and prefetched reads.
module spi_register_controller #(
  parameter int ADDR_WIDTH     = 7,
  parameter int AUTO_INCREMENT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sck,
  input  logic                  i_sdi,
  input  logic                  i_cs,
  output logic                  o_sdo,
  output logic                  o_sdo_oe,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic                  o_frame_active,
  output logic                  o_frame_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(AUTO_INCREMENT);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_sck_q;
  logic                  r_armed;
  logic [2:0]            r_bit_cnt;
  logic [6:0]            r_rx_shift;
  logic [7:0]            r_tx_shift;
  logic                  r_rd_load;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_sdo_oe;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_frame_active;
  logic                  r_frame_error;

  logic                  w_sck_rise_raw;
  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic [7:0]            w_byte;
  logic                  w_byte_done;
  logic [2:0]            w_cnt_eff;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_sck_rise_raw = i_sck & ~r_sck_q;
  assign w_sck_rise     = w_sck_rise_raw & ~i_cs;
  assign w_sck_fall     = ~i_sck & r_sck_q & ~i_cs;
  assign w_byte         = {r_rx_shift, i_sdi};
  assign w_byte_done    = w_sck_rise & (r_bit_cnt == 3'd7);
  // A rise coinciding with cs going high may complete a byte; that is not a partial frame.
  assign w_cnt_eff      = r_bit_cnt + {2'b00, w_sck_rise_raw};
  assign w_addr_inc     = r_addr + ADDR_STEP;

  assign o_sdo          = r_tx_shift[7];
  assign o_sdo_oe       = r_sdo_oe;
  assign o_wr_en        = r_wr_en;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;
  assign o_rd_en        = r_rd_en;
  assign o_rd_addr      = r_rd_addr;
  assign o_frame_active = r_frame_active;
  assign o_frame_error  = r_frame_error;

  // Frame state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; cs high always wins over a completing byte
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!i_cs && r_armed) w_state_next = S_CMD;
        else                  w_state_next = S_IDLE;
      end
      S_CMD: begin
        if (i_cs)             w_state_next = S_IDLE;
        else if (w_byte_done) w_state_next = w_byte[7] ? S_WRITE : S_READ;
        else                  w_state_next = S_CMD;
      end
      S_WRITE, S_READ: begin
        if (i_cs) w_state_next = S_IDLE;
        else      w_state_next = r_state;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift registers, address tracking and registered strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sck_q        <= 1'b1;
      r_armed        <= 1'b0;
      r_bit_cnt      <= 3'd0;
      r_rx_shift     <= 7'd0;
      r_tx_shift     <= 8'd0;
      r_rd_load      <= 1'b0;
      r_addr         <= '0;
      r_sdo_oe       <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= 8'd0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_frame_active <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_sck_q        <= i_sck;
      r_armed        <= r_armed | i_cs;
      r_sdo_oe       <= ~i_cs;
      r_frame_active <= (w_state_next != S_IDLE);
      r_wr_en        <= 1'b0;
      r_rd_en        <= 1'b0;
      r_frame_error  <= 1'b0;
      if (r_state == S_IDLE || i_cs) begin
        r_bit_cnt     <= 3'd0;
        r_tx_shift    <= 8'd0;
        r_rd_load     <= 1'b0;
        r_frame_error <= (r_state != S_IDLE) && i_cs && (w_cnt_eff != 3'd0);
      end else begin
        r_rd_load <= r_rd_en;
        if (w_sck_rise) begin
          r_rx_shift <= w_byte[6:0];
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        // The fall right after a byte boundary keeps the freshly loaded MSB on sdo
        if (r_rd_load) begin
          r_tx_shift <= i_rd_data;
        end else if (w_sck_fall && r_bit_cnt != 3'd0) begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              r_addr <= w_byte[ADDR_WIDTH-1:0];
              if (!w_byte[7]) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= w_byte[ADDR_WIDTH-1:0];
              end
            end
            S_WRITE: begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_byte;
              r_addr    <= w_addr_inc;
            end
            S_READ: begin
              r_addr    <= w_addr_inc;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_addr_inc;
            end
            default: begin
              r_addr <= r_addr;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Bench for spi_register_controller: two instances (auto-increment on/off) share the
// SPI inputs; a scoreboard of expected strobes is popped as the DUTs emit them.
module tb_spi_register_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sck, sdi, cs;
  logic       sdo1, oe1, wr1, rd1, fa1, fe1;
  logic [6:0] wa1, ra1;
  logic [7:0] wd1, rdd1;
  logic       sdo0, oe0, wr0, rd0, fa0, fe0;
  logic [6:0] wa0, ra0;
  logic [7:0] wd0, rdd0;

  spi_register_controller #(.ADDR_WIDTH(7), .AUTO_INCREMENT(1)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .i_cs(cs),
    .o_sdo(sdo1), .o_sdo_oe(oe1), .o_wr_en(wr1), .o_wr_addr(wa1), .o_wr_data(wd1),
    .o_rd_en(rd1), .o_rd_addr(ra1), .i_rd_data(rdd1),
    .o_frame_active(fa1), .o_frame_error(fe1));

  spi_register_controller #(.ADDR_WIDTH(7), .AUTO_INCREMENT(0)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_sck(sck), .i_sdi(sdi), .i_cs(cs),
    .o_sdo(sdo0), .o_sdo_oe(oe0), .o_wr_en(wr0), .o_wr_addr(wa0), .o_wr_data(wd0),
    .o_rd_en(rd0), .o_rd_addr(ra0), .i_rd_data(rdd0),
    .o_frame_active(fa0), .o_frame_error(fe0));

  int checks = 0;
  int failures = 0;
  int fe_cnt1 = 0;
  int fe_cnt0 = 0;
  logic [14:0] q_wr1[$];
  logic [14:0] q_wr0[$];
  logic [6:0]  q_rd1[$];
  logic [6:0]  q_rd0[$];
  logic [7:0]  mem[128];

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] a1_0;
    logic [6:0] a1_1;
    logic [6:0] a0_0;
    logic [6:0] a0_1;
  } wvec_t;
  wvec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register-file model: data valid exactly one cycle after rd_en, junk otherwise
  always @(posedge clk) begin
    rdd1 <= rd1 ? mem[ra1] : 8'hEE;
    rdd0 <= rd0 ? mem[ra0] : 8'hEE;
  end

  // Scoreboard: every strobe must match the head of its expected queue
  always @(negedge clk) begin
    if (fe1) fe_cnt1++;
    if (fe0) fe_cnt0++;
    if ((wr1 && rd1) || (wr0 && rd0)) begin
      checks++; failures++;
      $display("FAIL strobe_overlap actual=both required=one");
    end
    if (wr1) begin
      if (q_wr1.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr1_unexpected actual=%0h required=none", {wa1, wd1});
      end else check("wr1", {17'd0, wa1, wd1}, {17'd0, q_wr1.pop_front()});
    end
    if (wr0) begin
      if (q_wr0.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr0_unexpected actual=%0h required=none", {wa0, wd0});
      end else check("wr0", {17'd0, wa0, wd0}, {17'd0, q_wr0.pop_front()});
    end
    if (rd1) begin
      if (q_rd1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd1_unexpected actual=%0h required=none", ra1);
      end else check("rd1", {25'd0, ra1}, {25'd0, q_rd1.pop_front()});
    end
    if (rd0) begin
      if (q_rd0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd0_unexpected actual=%0h required=none", ra0);
      end else check("rd0", {25'd0, ra0}, {25'd0, q_rd0.pop_front()});
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic s1, output logic s0);
    sdi = b;
    clks(5);
    s1 = sdo1;
    s0 = sdo0;
    sck = 1'b1;
    clks(5);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] o1, output logic [7:0] o0);
    logic s1, s0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], s1, s0);
      o1[i] = s1;
      o0[i] = s0;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    logic s1, s0;
    for (int i = 0; i < n; i++) spi_bit(b[7-i], s1, s0);
  endtask

  task automatic cs_low(input string name);
    cs = 1'b0;
    clks(4);
    check({name, "_fa_on"}, {31'd0, fa1}, 32'd1);
    check({name, "_oe_on"}, {31'd0, oe1}, 32'd1);
  endtask

  task automatic cs_high(input string name);
    cs = 1'b1;
    clks(6);
    check({name, "_fa_off"}, {30'd0, fa1, fa0}, 32'd0);
    check({name, "_oe_off"}, {31'd0, oe1}, 32'd0);
  endtask

  task automatic check_queues(input string name);
    check({name, "_drained"}, q_wr1.size() + q_wr0.size() + q_rd1.size() + q_rd0.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out1"}, {4'd0, sdo1, oe1, wr1, wa1, wd1, rd1, ra1, fa1, fe1}, 32'd0);
    check({name, "_out0"}, {4'd0, sdo0, oe0, wr0, wa0, wd0, rd0, ra0, fa0, fe0}, 32'd0);
  endtask

  task automatic reset_in_frame(input string name);
    reset = 1'b1;
    clks(2);
    check_reset_outputs(name);
    reset = 1'b0;
    clks(4);
    check({name, "_no_resume"}, {30'd0, fa1, fa0}, 32'd0);
    cs = 1'b1;
    sck = 1'b0;
    clks(6);
    check_queues(name);
  endtask

  initial begin
    logic [7:0] o1, o0;
    int fe1_before, fe0_before;

    tbl[0] = '{8'h85, 8'hA5, 8'h3C, 7'h05, 7'h06, 7'h05, 7'h05};
    tbl[1] = '{8'hFF, 8'h11, 8'h22, 7'h7F, 7'h00, 7'h7F, 7'h7F};
    tbl[2] = '{8'h80, 8'h00, 8'hFF, 7'h00, 7'h01, 7'h00, 7'h00};
    tbl[3] = '{8'hAA, 8'h5A, 8'hC3, 7'h2A, 7'h2B, 7'h2A, 7'h2A};
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h99;
    mem[16] = 8'h5A;
    mem[17] = 8'hC3;

    reset = 1'b1; cs = 1'b1; sck = 1'b0; sdi = 1'b0;
    clks(3);
    check_reset_outputs("reset_idle");
    reset = 1'b0;
    clks(3);
    check("idle_fa", {30'd0, fa1, fa0}, 32'd0);

    // sck activity with cs held high must produce nothing
    spi_byte(8'h85, o1, o0);
    spi_byte(8'hA5, o1, o0);
    clks(3);
    check("cs_high_fa", {30'd0, fa1, fa0}, 32'd0);
    check("cs_high_fe", fe_cnt1 + fe_cnt0, 32'd0);
    check_queues("cs_high");

    for (int t = 0; t < 4; t++) begin
      q_wr1.push_back({tbl[t].a1_0, tbl[t].d0});
      q_wr1.push_back({tbl[t].a1_1, tbl[t].d1});
      q_wr0.push_back({tbl[t].a0_0, tbl[t].d0});
      q_wr0.push_back({tbl[t].a0_1, tbl[t].d1});
      cs_low("wr");
      spi_byte(tbl[t].cmd, o1, o0);
      spi_byte(tbl[t].d0, o1, o0);
      spi_byte(tbl[t].d1, o1, o0);
      cs_high("wr");
      check_queues("wr_frame");
    end
    check("wr_no_fe", fe_cnt1 + fe_cnt0, 32'd0);

    // Read with prefetch and trailing prefetch
    q_rd1.push_back(7'h10); q_rd1.push_back(7'h11); q_rd1.push_back(7'h12);
    q_rd0.push_back(7'h10); q_rd0.push_back(7'h10); q_rd0.push_back(7'h10);
    cs_low("rd");
    spi_byte(8'h10, o1, o0);
    check("rd_cmd_sdo", {24'd0, o1}, 32'h00);
    spi_byte(8'h00, o1, o0);
    check("rd_b0", {24'd0, o1}, 32'h5A);
    check("rd_b0_noinc", {24'd0, o0}, 32'h5A);
    spi_byte(8'hFF, o1, o0);
    check("rd_b1", {24'd0, o1}, 32'hC3);
    check("rd_b1_noinc", {24'd0, o0}, 32'h5A);
    cs_high("rd");
    check_queues("rd");

    // Abort after 5 data bits
    fe1_before = fe_cnt1; fe0_before = fe_cnt0;
    cs_low("abort");
    spi_byte(8'h81, o1, o0);
    spi_bits(8'hA5, 5);
    cs_high("abort");
    check("abort_fe1", fe_cnt1 - fe1_before, 32'd1);
    check("abort_fe0", fe_cnt0 - fe0_before, 32'd1);
    check_queues("abort");

    // cs rise in the same cycle as the 8th sck rise
    fe1_before = fe_cnt1;
    cs_low("coll");
    spi_byte(8'h81, o1, o0);
    spi_bits(8'hA5, 7);
    sdi = 1'b1;
    clks(5);
    sck = 1'b1;
    cs = 1'b1;
    clks(6);
    sck = 1'b0;
    clks(6);
    check("coll_fe", fe_cnt1 - fe1_before, 32'd0);
    check("coll_fa", {30'd0, fa1, fa0}, 32'd0);
    check_queues("coll");

    // Reset in CMD, WRITE and READ
    cs_low("rst_cmd");
    spi_bits(8'h85, 3);
    reset_in_frame("rst_cmd");
    cs_low("rst_wr");
    spi_byte(8'h85, o1, o0);
    spi_bits(8'hA5, 4);
    reset_in_frame("rst_wr");
    q_rd1.push_back(7'h10); q_rd0.push_back(7'h10);
    cs_low("rst_rd");
    spi_byte(8'h10, o1, o0);
    spi_bits(8'h00, 4);
    reset_in_frame("rst_rd");

    // Normal decode after reset
    q_wr1.push_back({7'h05, 8'h77}); q_wr0.push_back({7'h05, 8'h77});
    cs_low("post_rst");
    spi_byte(8'h85, o1, o0);
    spi_byte(8'h77, o1, o0);
    cs_high("post_rst");
    check_queues("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
